// File: rtl/sample_accumulator_pkg.sv
// Shared types and widths for the windowed sample accumulator.
package accum_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } accum_state_t;

endpackage : accum_pkg

// File: rtl/sample_accumulator_if.sv
// Sample-in / window-total-out bundle between the sample source and the accumulator.
interface sample_accumulator_if;
    import accum_pkg::*;

    logic              clear;
    logic              data_ready;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              sum_valid;
    logic [DATA_W-1:0] sum_out;
    logic              overflow_err;

    modport master (
        output clear, data_ready, data_in,
        input  busy, sum_valid, sum_out, overflow_err
    );

    modport slave (
        input  clear, data_ready, data_in,
        output busy, sum_valid, sum_out, overflow_err
    );
endinterface : sample_accumulator_if

// File: rtl/sample_accumulator_adder.sv
// Combinational 16-bit unsigned adder; the carry-out is reported as overflow.
module adder_16bit
    import accum_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              carry_in_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              overflow_o
);

    // Widen by one bit so the carry-out falls into the top bit.
    always_comb begin
        {overflow_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, carry_in_i};
    end

endmodule : adder_16bit

// File: rtl/sample_accumulator.sv
// Windowed accumulator: sums NUM_SAMPLES unsigned samples, then presents the
// window total for one cycle. An overflowing window parks in ERR until clear.
//
//  state | meaning
//  IDLE  | ready for a sample (busy=0)
//  ADD   | add captured sample into the running total
//  DONE  | window complete; publish total, reset acc/count
//  ERR   | total exceeded 16 bits; wait for clear or reset
module sample_accumulator
    import accum_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    sample_accumulator_if.slave  bus
);

    localparam int                CNT_W    = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_SAMPLES - 1);

    accum_state_t      state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] sum_out_q, sum_out_d;
    logic              sum_valid_q, sum_valid_d;
    logic              ovf_err_q, ovf_err_d;

    logic [DATA_W-1:0] add_sum;
    logic              add_ovf;

    adder_16bit u_adder (
        .a_i        (acc_q),
        .b_i        (sample_q),
        .carry_in_i (1'b0),
        .sum_o      (add_sum),
        .overflow_o (add_ovf)
    );

    // Next-state and datapath decode; clear overrides every state.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sample_d    = sample_q;
        count_d     = count_q;
        sum_out_d   = sum_out_q;
        sum_valid_d = 1'b0;
        ovf_err_d   = ovf_err_q;

        if (bus.clear) begin
            state_d   = IDLE;
            acc_d     = '0;
            sample_d  = '0;
            count_d   = '0;
            ovf_err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.data_ready) begin
                        sample_d = bus.data_in;
                        state_d  = ADD;
                    end
                end
                ADD: begin
                    if (add_ovf) begin
                        ovf_err_d = 1'b1;
                        state_d   = ERR;
                    end else begin
                        acc_d   = add_sum;
                        count_d = count_q + CNT_W'(1);
                        state_d = (count_q == CNT_LAST) ? DONE : IDLE;
                    end
                end
                DONE: begin
                    // Output registers load here so the pulse and the total appear together.
                    sum_out_d   = acc_q;
                    sum_valid_d = 1'b1;
                    acc_d       = '0;
                    count_d     = '0;
                    state_d     = IDLE;
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sample_q    <= '0;
            count_q     <= '0;
            sum_out_q   <= '0;
            sum_valid_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sample_q    <= sample_d;
            count_q     <= count_d;
            sum_out_q   <= sum_out_d;
            sum_valid_q <= sum_valid_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.sum_valid    = sum_valid_q;
    assign bus.sum_out      = sum_out_q;
    assign bus.overflow_err = ovf_err_q;

endmodule : sample_accumulator
